// File: rtl/de_hazard_scoreboard_pkg.sv
// Shared pipeline definitions: register-file geometry and port-slice packing helpers.
package de_hazard_scoreboard_pkg;

    localparam int unsigned DEF_REGNOBITS = 5;
    localparam int unsigned DEF_NREGS     = 1 << DEF_REGNOBITS;

    // Low bit of port `port` in a flat vector of `width`-bit slices.
    function automatic int unsigned port_lo(input int unsigned port, input int unsigned width);
        return port * width;
    endfunction

    // Bits needed to count 0..nports simultaneous releases.
    function automatic int unsigned rel_bits(input int unsigned nports);
        return $clog2(nports + 1);
    endfunction

endpackage

// File: rtl/de_hazard_scoreboard_wb_release_counter.sv
// Reduces NWB write-back release ports into a per-register release count.
module wb_release_counter
    import de_hazard_scoreboard_pkg::*;
#(
    parameter int unsigned NREGS     = DEF_NREGS,
    parameter int unsigned REGNOBITS = DEF_REGNOBITS,
    parameter int unsigned NWB       = 1,
    parameter int unsigned RELBITS   = rel_bits(NWB)
) (
    input  logic [NWB-1:0]           wb_valid,
    input  logic [NWB*REGNOBITS-1:0] wb_regno,
    output logic [NREGS*RELBITS-1:0] rel
);

    logic [RELBITS-1:0] rel_a [NREGS];

    // Count matching valid ports per register; r0 is never tracked.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            rel_a[r] = '0;
            for (int k = 0; k < NWB; k++) begin
                if (r != 0 && wb_valid[k] &&
                    wb_regno[port_lo(k, REGNOBITS) +: REGNOBITS] == REGNOBITS'(r)) begin
                    rel_a[r] = rel_a[r] + RELBITS'(1);
                end
            end
        end
    end

    // Pack per-register counts into the flat output.
    always_comb begin
        rel = '0;
        for (int r = 0; r < NREGS; r++) begin
            rel[r*RELBITS +: RELBITS] = rel_a[r];
        end
    end

endmodule

// File: rtl/de_hazard_scoreboard.sv
// Decode-stage hazard scoreboard: per-register in-flight producer counters,
// RAW / counter-full stall generation and write-back release accounting.
module de_hazard_scoreboard
    import de_hazard_scoreboard_pkg::*;
#(
    parameter int unsigned NREGS     = DEF_NREGS,
    parameter int unsigned REGNOBITS = DEF_REGNOBITS,
    parameter int unsigned CNTBITS   = 2,
    parameter int unsigned NWB       = 1,
    parameter int unsigned WB_BYPASS = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     dec_valid,
    input  logic [REGNOBITS-1:0]     dec_rs1,
    input  logic [REGNOBITS-1:0]     dec_rs2,
    input  logic                     dec_use_rs1,
    input  logic                     dec_use_rs2,
    input  logic [REGNOBITS-1:0]     dec_rd,
    input  logic                     dec_wr_reg,
    input  logic                     ext_stall,
    input  logic [NWB-1:0]           wb_valid,
    input  logic [NWB*REGNOBITS-1:0] wb_regno,
    output logic                     stall,
    output logic                     issue,
    output logic [NREGS-1:0]         busy_mask,
    output logic                     underflow_err
);

    localparam int unsigned RELBITS = rel_bits(NWB);
    // Wide enough for cnt+1 and for any release count without wrap.
    localparam int unsigned WBITS   = ((CNTBITS > RELBITS) ? CNTBITS : RELBITS) + 1;

    logic [CNTBITS-1:0]       cnt_q [NREGS];
    logic [CNTBITS-1:0]       cnt_d [NREGS];
    logic [CNTBITS-1:0]       eff   [NREGS];
    logic [WBITS-1:0]         rel_w [NREGS];
    logic [NREGS*RELBITS-1:0] rel_flat;
    logic [NREGS-1:0]         busy_d;
    logic [NREGS-1:0]         busy_q;
    logic                     uf_q;
    logic                     uf_set;
    logic                     raw1, raw2, full;

    wb_release_counter #(
        .NREGS     (NREGS),
        .REGNOBITS (REGNOBITS),
        .NWB       (NWB),
        .RELBITS   (RELBITS)
    ) u_rel (
        .wb_valid (wb_valid),
        .wb_regno (wb_regno),
        .rel      (rel_flat)
    );

    // Effective count seen by the hazard check; bypass subtracts same-cycle releases.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            rel_w[r] = WBITS'(rel_flat[r*RELBITS +: RELBITS]);
            eff[r]   = cnt_q[r];
            if (r == 0) begin
                eff[r] = '0;
            end else if (WB_BYPASS != 0) begin
                if (rel_w[r] >= WBITS'(cnt_q[r])) eff[r] = '0;
                else                              eff[r] = CNTBITS'(WBITS'(cnt_q[r]) - rel_w[r]);
            end
        end
    end

    // Hazard detection and issue decision.
    always_comb begin
        raw1  = dec_use_rs1 && (dec_rs1 != '0) && (eff[dec_rs1] != '0);
        raw2  = dec_use_rs2 && (dec_rs2 != '0) && (eff[dec_rs2] != '0);
        full  = dec_wr_reg && (dec_rd != '0) && (eff[dec_rd] == {CNTBITS{1'b1}});
        stall = ext_stall | (dec_valid & (raw1 | raw2 | full));
        issue = dec_valid & ~stall;
    end

    // Counter next state: add issue, subtract releases, saturate at zero on underflow.
    always_comb begin
        uf_set = 1'b0;
        for (int r = 0; r < NREGS; r++) begin
            logic [WBITS-1:0] sum;
            sum = WBITS'(cnt_q[r]);
            if (issue && dec_wr_reg && r != 0 && dec_rd == REGNOBITS'(r)) begin
                sum = sum + WBITS'(1);
            end
            if (r == 0) begin
                cnt_d[r] = '0;
            end else if (rel_w[r] > sum) begin
                cnt_d[r] = '0;
                uf_set   = 1'b1;
            end else begin
                cnt_d[r] = CNTBITS'(sum - rel_w[r]);
            end
            busy_d[r] = (cnt_d[r] != '0);
        end
    end

    // State registers with synchronous reset discarding all in-flight counts.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) cnt_q[r] <= '0;
            busy_q <= '0;
            uf_q   <= 1'b0;
        end else begin
            for (int r = 0; r < NREGS; r++) cnt_q[r] <= cnt_d[r];
            busy_q <= busy_d;
            uf_q   <= uf_q | uf_set;
        end
    end

    assign busy_mask     = busy_q;
    assign underflow_err = uf_q;

endmodule

// File: tb/tb_de_hazard_scoreboard.sv
// Self-checking bench: driver pushes expected outputs from a reference model,
// a negedge monitor pops and compares.
module tb_de_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        dec_valid, dec_use_rs1, dec_use_rs2, dec_wr_reg, ext_stall;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic [1:0]  wb_valid;
    logic [9:0]  wb_regno;
    logic        stall, issue, underflow_err;
    logic [31:0] busy_mask;

    always #5 clk = ~clk;

    de_hazard_scoreboard #(
        .NREGS     (32),
        .REGNOBITS (5),
        .CNTBITS   (2),
        .NWB       (2),
        .WB_BYPASS (1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .dec_valid     (dec_valid),
        .dec_rs1       (dec_rs1),
        .dec_rs2       (dec_rs2),
        .dec_use_rs1   (dec_use_rs1),
        .dec_use_rs2   (dec_use_rs2),
        .dec_rd        (dec_rd),
        .dec_wr_reg    (dec_wr_reg),
        .ext_stall     (ext_stall),
        .wb_valid      (wb_valid),
        .wb_regno      (wb_regno),
        .stall         (stall),
        .issue         (issue),
        .busy_mask     (busy_mask),
        .underflow_err (underflow_err)
    );

    typedef struct packed {
        logic        stall;
        logic        issue;
        logic [31:0] busy;
        logic        uf;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   step_no = 0;

    // Reference model: in-flight producer count per register, sticky underflow flag.
    int   m_cnt[32];
    bit   m_uf;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h, required %h", name, step_no, act, req);
        end
    endfunction

    // Monitor: compare every presented output against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("stall", 32'(stall), 32'(e.stall));
            chk("issue", 32'(issue), 32'(e.issue));
            chk("busy_mask", busy_mask, e.busy);
            chk("underflow_err", 32'(underflow_err), 32'(e.uf));
        end
    end

    task automatic step(input bit rst, input bit v, input int rs1, input bit u1, input int rs2,
                        input bit u2, input int rd, input bit wr, input bit ext,
                        input bit wv0, input int wr0, input bit wv1, input int wr1);
        int   rel[32];
        int   eff[32];
        bit   hz, st, is;
        exp_t e;
        reset       = rst;
        dec_valid   = v;
        dec_rs1     = 5'(rs1);
        dec_use_rs1 = u1;
        dec_rs2     = 5'(rs2);
        dec_use_rs2 = u2;
        dec_rd      = 5'(rd);
        dec_wr_reg  = wr;
        ext_stall   = ext;
        wb_valid    = {wv1, wv0};
        wb_regno    = {5'(wr1), 5'(wr0)};
        for (int r = 0; r < 32; r++) rel[r] = 0;
        if (wv0 && wr0 != 0) rel[wr0]++;
        if (wv1 && wr1 != 0) rel[wr1]++;
        for (int r = 0; r < 32; r++) eff[r] = (m_cnt[r] > rel[r]) ? m_cnt[r] - rel[r] : 0;
        hz = (u1 && rs1 != 0 && eff[rs1] != 0) || (u2 && rs2 != 0 && eff[rs2] != 0) ||
             (wr && rd != 0 && eff[rd] == 3);
        st = ext || (v && hz);
        is = v && !st;
        e.stall = st;
        e.issue = is;
        e.uf    = m_uf;
        for (int r = 0; r < 32; r++) e.busy[r] = (m_cnt[r] != 0);
        exp_q.push_back(e);
        @(posedge clk);
        if (rst) begin
            for (int r = 0; r < 32; r++) m_cnt[r] = 0;
            m_uf = 0;
        end else begin
            for (int r = 1; r < 32; r++) begin
                int n;
                n = m_cnt[r] + ((is && wr && rd == r) ? 1 : 0) - rel[r];
                if (n < 0) begin
                    n    = 0;
                    m_uf = 1;
                end
                m_cnt[r] = n;
            end
        end
        step_no++;
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr_rd(input int rd);
        step(0, 1, 0, 0, 0, 0, rd, 1, 0, 0, 0, 0, 0);
    endtask

    task automatic release1(input int r);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, r, 0, 0);
    endtask

    initial begin
        for (int r = 0; r < 32; r++) m_cnt[r] = 0;
        m_uf = 0;
        reset = 1; dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_use_rs1 = 0; dec_use_rs2 = 0;
        dec_rd = 0; dec_wr_reg = 0; ext_stall = 0; wb_valid = 0; wb_regno = 0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        // RAW on r5, released by write-back with bypass.
        wr_rd(5);
        step(0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 5, 1, 0, 0, 0, 0, 0, 1, 5, 0, 0);
        idle();
        // Counter-full on r7.
        wr_rd(7); wr_rd(7); wr_rd(7);
        wr_rd(7); wr_rd(7);
        step(0, 1, 0, 0, 0, 0, 7, 1, 0, 1, 7, 0, 0);
        release1(7); release1(7); release1(7);
        idle();
        // Issue and release on the same register net to no change.
        wr_rd(3);
        step(0, 1, 0, 0, 0, 0, 3, 1, 0, 1, 3, 0, 0);
        idle();
        release1(3);
        idle();
        // Dual-port release of r9, then underflow.
        wr_rd(9); wr_rd(9);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 1, 9);
        idle();
        wr_rd(9);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 1, 9);
        idle(); idle();
        // r0 never tracked; external stall blocks increment.
        step(0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        idle();
        step(0, 1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0, 0);
        step(0, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Reset discards in-flight producers; late release then underflows.
        wr_rd(2); wr_rd(2); wr_rd(6);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        release1(6);
        idle();
        // Randomized traffic on a small register set to provoke hazards.
        for (int i = 0; i < 2000; i++) begin
            int  rs1, rs2, rd, r0, r1;
            bit  v0, v1;
            rs1 = $urandom_range(0, 7);
            rs2 = $urandom_range(0, 7);
            rd  = $urandom_range(0, 7);
            r0  = $urandom_range(0, 7);
            r1  = $urandom_range(0, 7);
            v0  = ($urandom_range(0, 2) == 0) && (m_cnt[r0] > 0 || $urandom_range(0, 9) == 0);
            v1  = ($urandom_range(0, 3) == 0) && (m_cnt[r1] > 0 || $urandom_range(0, 9) == 0);
            step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
                 rs1, $urandom_range(0, 1) == 1, rs2, $urandom_range(0, 1) == 1,
                 rd, $urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0,
                 v0, r0, v1, r1);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/de_hazard_scoreboard.md
DE_HAZARD_SCOREBOARD -- requirements
Module: de_hazard_scoreboard

Interface
REQ-001 SHALL have parameter NREGS, default 32, number of architectural registers.
REQ-002 SHALL have parameter REGNOBITS, default 5, register index width; NREGS SHALL equal 2**REGNOBITS.
REQ-003 SHALL have parameter CNTBITS, default 2, width of the per-register in-flight producer counter.
REQ-004 SHALL have parameter NWB, default 1, number of write-back release ports.
REQ-005 SHALL have parameter WB_BYPASS, default 1; when 1, same-cycle releases are visible to the hazard check.
REQ-006 SHALL have input clk, 1 bit: clock, rising edge.
REQ-007 SHALL have input reset, 1 bit: reset, synchronous, active-high.
REQ-008 SHALL have input dec_valid, 1 bit: the decode slot holds a valid instruction.
REQ-009 SHALL have inputs dec_rs1 and dec_rs2, REGNOBITS each: source register indices.
REQ-010 SHALL have inputs dec_use_rs1 and dec_use_rs2, 1 bit each: the source is read.
REQ-011 SHALL have input dec_rd, REGNOBITS: destination index; dec_wr_reg, 1 bit: the instruction writes dec_rd.
REQ-012 SHALL have input ext_stall, 1 bit: external stall, e.g. branch mispredict from AGEX.
REQ-013 SHALL have input wb_valid, NWB bits, and wb_regno, NWB*REGNOBITS bits: per-port register release, port k in slice k.
REQ-014 SHALL have output stall, 1 bit, combinational: hold FE and bubble the DE latch.
REQ-015 SHALL have output issue, 1 bit, combinational: dec_valid & ~stall.
REQ-016 SHALL have output busy_mask, NREGS bits, registered: bit r = (cnt[r] != 0).
REQ-017 SHALL have output underflow_err, 1 bit, registered, sticky.

Function
REQ-018 SHALL hold one CNTBITS counter cnt[r] per register; register 0 SHALL never be tracked, and cnt[0] SHALL read 0.
REQ-019 SHALL compute rel[r] as the number of ports k with wb_valid[k]=1 and wb_regno[k]=r, r!=0; duplicate ports SHALL each count.
REQ-020 SHALL compute the effective count eff[r] = sat0(cnt[r]-rel[r]) when WB_BYPASS=1, and cnt[r] otherwise.
REQ-021 SHALL detect a RAW hazard when dec_use_rsN=1, dec_rsN!=0, and eff[dec_rsN]!=0, for N=1 or 2.
REQ-022 SHALL detect a counter-full hazard when dec_wr_reg=1, dec_rd!=0, and eff[dec_rd] equals 2**CNTBITS-1.
REQ-023 SHALL assert stall = ext_stall | (dec_valid & (RAW | counter-full)).
REQ-024 SHALL take inc[r]=1 when issue=1, dec_wr_reg=1, dec_rd=r, and r!=0.
REQ-025 SHALL set, at each rising edge, cnt[r] <= cnt[r] + inc[r] - rel[r]; a simultaneous inc and rel on the same register SHALL net correctly, including producing no change.
REQ-026 SHALL, when rel[r] exceeds cnt[r]+inc[r], saturate cnt[r] at 0 and set underflow_err the next cycle.
REQ-027 SHALL, with ext_stall=1, perform no increment; releases SHALL still apply.
REQ-028 SHALL, with dec_valid=0, assert stall only from ext_stall, and SHALL perform no increment.
REQ-029 SHALL give busy_mask and cnt a latency of one cycle from issue or release to visibility.

Reset
REQ-030 SHALL, when reset=1 at a rising edge, clear all cnt[r] to 0, busy_mask to 0, and underflow_err to 0, ignoring same-cycle issue and release.
REQ-031 SHALL apply reset mid-operation with in-flight producers by discarding all counts; late releases SHALL then raise underflow_err.
REQ-032 SHALL drive stall and issue purely combinationally from the current inputs and state during reset.

Structure
REQ-033 SHALL take REGNOBITS, NREGS defaults, and the port-slice packing helper from the shared define/package file used by the pipeline stages.
REQ-034 SHALL implement the NWB-port release-count reduction, producing rel[r], as one sub-module named wb_release_counter.
REQ-035 SHALL keep the register file out of this block; the register file write on negedge is what justifies WB_BYPASS=1.

Verification
REQ-036 SHALL be verified with: issue rd=5 (wr_reg=1), then next cycle dec_rs1=5 use_rs1=1 -> stall=1, busy_mask[5]=1; wb port0 releases r5 -> with WB_BYPASS=1 stall drops that cycle, cnt[5]=0 next.
REQ-037 SHALL be verified with: CNTBITS=2, issue rd=7 three times with no release -> cnt[7]=3; fourth dec_rd=7 wr_reg -> stall=1 until one release of r7.
REQ-038 SHALL be verified with: issue rd=3 in the same cycle as a release of r3 while cnt[3]=1 -> cnt[3] remains 1, busy_mask[3]=1.
REQ-039 SHALL be verified with: NWB=2, both ports releasing r9 with cnt[9]=2 -> cnt[9]=0; both ports releasing r9 with cnt[9]=1 -> cnt[9]=0 and underflow_err=1 sticky.
REQ-040 SHALL be verified with: dec_rd=0 wr_reg=1 and dec_rs1=0 -> no stall and no count; ext_stall=1 with dec_rd=4 -> stall=1, issue=0, cnt[4] unchanged.
REQ-041 SHALL be verified with: cnt[2]=2 and cnt[6]=1, then reset pulse -> busy_mask=0, underflow_err=0, and stall=0 on the next valid instruction reading r2.
